// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and helpers for the hazard scoreboard
// Optional statistics counters are enabled with HAZARD_SCOREBOARD_STATS_EN.
package hazard_scoreboard_pkg;

    localparam int SB_ADDR_W = 5;
    localparam int SB_DATA_W = 32;
    localparam int SB_DEPTH  = 5;
    localparam int SB_LAT_W  = $clog2(SB_DEPTH + 1);

    // fwd_sel value meaning "take the register file read data"
    localparam int SB_FWD_RF = 0;

    typedef logic                 Signal;
    typedef logic [SB_ADDR_W-1:0] RegAddr;

    typedef struct packed {
        Signal                valid;
        RegAddr               dst;
        logic [SB_LAT_W-1:0]  lat;
    } SbEntry;

    // A result can never be ready before slot 1 nor later than the last slot.
    function automatic int sb_clamp_lat(input int lat, input int depth);
        if (lat < 1) begin
            return 1;
        end else if (lat > depth) begin
            return depth;
        end
        return lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_src_match.sv
// rtl/hazard_scoreboard_sb_src_match.sv - youngest-match search and operand mux for one source
// Optional statistics counters are enabled with HAZARD_SCOREBOARD_STATS_EN.
module sb_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    parameter int DEPTH  = SB_DEPTH,
    parameter int LAT_W  = $clog2(DEPTH + 1)
) (
    input  logic                      used,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         rf,
    input  logic [DEPTH-1:0]          slot_valid,
    input  logic [DEPTH*ADDR_W-1:0]   slot_dst,
    input  logic [DEPTH*LAT_W-1:0]    slot_lat,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    output logic [LAT_W-1:0]          sel,
    output logic [DATA_W-1:0]         data,
    output logic                      stall_req
);

    logic             hit;
    logic [LAT_W-1:0] hit_idx;
    logic [LAT_W-1:0] hit_lat;
    logic             ready;

    // Scan oldest to youngest so the youngest matching slot is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_lat = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && (addr != '0) && slot_valid[k-1] &&
                (slot_dst[(k-1)*ADDR_W +: ADDR_W] == addr)) begin
                hit     = 1'b1;
                hit_idx = LAT_W'(k);
                hit_lat = slot_lat[(k-1)*LAT_W +: LAT_W];
            end
        end
    end

    assign ready     = hit && (hit_idx >= hit_lat);
    assign stall_req = hit && !ready;

    always_comb begin
        sel  = LAT_W'(SB_FWD_RF);
        data = rf;
        if (ready) begin
            sel = hit_idx;
            for (int k = 1; k <= DEPTH; k++) begin
                if (hit_idx == LAT_W'(k)) begin
                    data = stage_data[(k-1)*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight write tracking, decode stall and operand forwarding
// Optional statistics counters are enabled with HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W      = SB_ADDR_W,
    parameter int DATA_W      = SB_DATA_W,
    parameter int DEPTH       = SB_DEPTH,
    parameter int NSRC        = 2,
    parameter int FLUSH_DEPTH = 2,
    localparam int LAT_W      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [ADDR_W-1:0]         issue_dst,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic                      flush,
    input  logic [NSRC-1:0]           src_used,
    input  logic [NSRC*ADDR_W-1:0]    src_addr,
    input  logic [NSRC*DATA_W-1:0]    rf_data,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    output logic                      stall,
    output logic [NSRC*LAT_W-1:0]     fwd_sel,
    output logic [NSRC*DATA_W-1:0]    src_data,
    output logic [LAT_W-1:0]          inflight
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               fwd_cnt
`endif
);

    typedef struct packed {
        Signal              valid;
        logic [ADDR_W-1:0]  dst;
        logic [LAT_W-1:0]   lat;
    } slot_t;

    slot_t                   slots     [1:DEPTH];
    slot_t                   slots_nxt [1:DEPTH];
    logic [DEPTH-1:0]        slot_valid;
    logic [DEPTH*ADDR_W-1:0] slot_dst;
    logic [DEPTH*LAT_W-1:0]  slot_lat;
    logic [NSRC-1:0]         stall_req;
    logic                    issue_load;
    logic [LAT_W-1:0]        lat_in;
    logic [LAT_W-1:0]        valid_nxt_cnt;

    always_comb begin
        slot_valid = '0;
        slot_dst   = '0;
        slot_lat   = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            slot_valid[k-1]                  = slots[k].valid;
            slot_dst[(k-1)*ADDR_W +: ADDR_W] = slots[k].dst;
            slot_lat[(k-1)*LAT_W +: LAT_W]   = slots[k].lat;
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        sb_src_match #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .LAT_W  (LAT_W)
        ) u_match (
            .used       (src_used[s]),
            .addr       (src_addr[s*ADDR_W +: ADDR_W]),
            .rf         (rf_data[s*DATA_W +: DATA_W]),
            .slot_valid (slot_valid),
            .slot_dst   (slot_dst),
            .slot_lat   (slot_lat),
            .stage_data (stage_data),
            .sel        (fwd_sel[s*LAT_W +: LAT_W]),
            .data       (src_data[s*DATA_W +: DATA_W]),
            .stall_req  (stall_req[s])
        );
    end

    // Flush wins over stall: a killed instruction never holds decode.
    assign stall      = (|stall_req) && issue_valid && !flush;
    assign issue_load = issue_valid && issue_wr && !stall && !flush;
    assign lat_in     = LAT_W'(sb_clamp_lat(int'(issue_lat), DEPTH));

    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            slots_nxt[k] = '0;
        end
        for (int k = 2; k <= DEPTH; k++) begin
            if (!(flush && (k <= FLUSH_DEPTH))) begin
                slots_nxt[k] = slots[k-1];
            end
        end
        if (issue_load) begin
            slots_nxt[1].valid = 1'b1;
            slots_nxt[1].dst   = issue_dst;
            slots_nxt[1].lat   = lat_in;
        end
        valid_nxt_cnt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            valid_nxt_cnt = valid_nxt_cnt + LAT_W'(slots_nxt[k].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                slots[k] <= '0;
            end
            inflight <= '0;
        end else begin
            slots    <= slots_nxt;
            inflight <= valid_nxt_cnt;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!stall && (|fwd_sel) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
